// File: rtl/id_stage_pkg.sv
// Shared definitions for the LA32R decode stage: bus widths, alu_op bit
// positions, opcode field values and the dest-bus hazard helper.
package id_stage_pkg;

  localparam int IF_ID_W  = 64;
  localparam int ID_EXE_W = 150;
  localparam int BR_W     = 34;
  localparam int WB_RF_W  = 38;
  localparam int ALU_OP_W = 12;

  // alu_op one-hot bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // inst[31:26]
  localparam logic [5:0] OP6_SPECIAL = 6'h00;
  localparam logic [5:0] OP6_MEM     = 6'h0a;
  localparam logic [5:0] OP6_JIRL    = 6'h13;
  localparam logic [5:0] OP6_B       = 6'h14;
  localparam logic [5:0] OP6_BL      = 6'h15;
  localparam logic [5:0] OP6_BEQ     = 6'h16;
  localparam logic [5:0] OP6_BNE     = 6'h17;
  // inst[31:25]
  localparam logic [6:0] OP7_LU12I   = 7'h0a;
  // inst[25:22]
  localparam logic [3:0] OP4_3R      = 4'h0;
  localparam logic [3:0] OP4_SHIFT_I = 4'h1;
  localparam logic [3:0] OP4_LD_W    = 4'h2;
  localparam logic [3:0] OP4_ST_W    = 4'h6;
  localparam logic [3:0] OP4_ADDI_W  = 4'ha;
  // inst[21:20]
  localparam logic [1:0] OP2_3R      = 2'b01;
  localparam logic [1:0] OP2_SHIFT_I = 2'b00;
  // inst[19:15]
  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SUB  = 5'h02;
  localparam logic [4:0] F_SLT  = 5'h04;
  localparam logic [4:0] F_SLTU = 5'h05;
  localparam logic [4:0] F_NOR  = 5'h08;
  localparam logic [4:0] F_AND  = 5'h09;
  localparam logic [4:0] F_OR   = 5'h0a;
  localparam logic [4:0] F_XOR  = 5'h0b;
  localparam logic [4:0] F_SLLI = 5'h01;
  localparam logic [4:0] F_SRLI = 5'h09;
  localparam logic [4:0] F_SRAI = 5'h11;

  // A dest bus entry {valid, dest} matches a source register
  function automatic logic dest_hit(input logic [5:0] dest_bus, input logic [4:0] src);
    return dest_bus[5] && (dest_bus[4:0] == src);
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 GPR file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero, same-cycle write-through to both read ports.
module id_stage_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem [32];

  // NOTE: the storage array has no reset; software never reads a GPR before
  // writing it, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) mem[waddr] <= wdata;
  end

  always_comb begin
    if (raddr1 == 5'd0)                 rdata1 = 32'd0;
    else if (we && waddr == raddr1)     rdata1 = wdata;
    else                                rdata1 = mem[raddr1];
  end

  always_comb begin
    if (raddr2 == 5'd0)                 rdata2 = 32'd0;
    else if (we && waddr == raddr2)     rdata2 = wdata;
    else                                rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// LA32R decode stage: captures {pc, inst} from IF, decodes, reads GPRs,
// interlocks on EXE/MEM RAW hazards and resolves branches for IF.
module id_stage
  import id_stage_pkg::*;
#(
  parameter bit PC_RESET_NOP = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                IF_to_ID_Valid,
  input  logic [IF_ID_W-1:0]  IF_to_ID_Bus,
  output logic                ID_Allow_in,
  output logic [BR_W-1:0]     br_bus,
  input  logic                EXE_Allow_in,
  output logic                ID_to_EXE_Valid,
  output logic [ID_EXE_W-1:0] ID_to_EXE_Bus,
  input  logic [5:0]          EXE_dest_bus,
  input  logic [5:0]          MEM_dest_bus,
  input  logic [WB_RF_W-1:0]  WB_to_RF_Bus
);

  logic               id_valid;
  logic [IF_ID_W-1:0] if_id_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      if_id_q  <= '0;
    end else if (ID_Allow_in) begin
      id_valid <= IF_to_ID_Valid;
      if (IF_to_ID_Valid) if_id_q <= IF_to_ID_Bus;
    end
  end

  logic [31:0] pc, inst;
  assign pc   = if_id_q[63:32];
  assign inst = if_id_q[31:0];

  logic [4:0] rd, rj, rk;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  logic grp_3r, grp_shi;
  assign grp_3r  = inst[31:26] == OP6_SPECIAL && inst[25:22] == OP4_3R      && inst[21:20] == OP2_3R;
  assign grp_shi = inst[31:26] == OP6_SPECIAL && inst[25:22] == OP4_SHIFT_I && inst[21:20] == OP2_SHIFT_I;

  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
  logic i_slli, i_srli, i_srai, i_addi, i_lu12i, i_ld, i_st;
  logic i_jirl, i_b, i_bl, i_beq, i_bne;
  assign i_add   = grp_3r  && inst[19:15] == F_ADD;
  assign i_sub   = grp_3r  && inst[19:15] == F_SUB;
  assign i_slt   = grp_3r  && inst[19:15] == F_SLT;
  assign i_sltu  = grp_3r  && inst[19:15] == F_SLTU;
  assign i_nor   = grp_3r  && inst[19:15] == F_NOR;
  assign i_and   = grp_3r  && inst[19:15] == F_AND;
  assign i_or    = grp_3r  && inst[19:15] == F_OR;
  assign i_xor   = grp_3r  && inst[19:15] == F_XOR;
  assign i_slli  = grp_shi && inst[19:15] == F_SLLI;
  assign i_srli  = grp_shi && inst[19:15] == F_SRLI;
  assign i_srai  = grp_shi && inst[19:15] == F_SRAI;
  assign i_addi  = inst[31:26] == OP6_SPECIAL && inst[25:22] == OP4_ADDI_W;
  assign i_ld    = inst[31:26] == OP6_MEM && inst[25:22] == OP4_LD_W;
  assign i_st    = inst[31:26] == OP6_MEM && inst[25:22] == OP4_ST_W;
  assign i_lu12i = inst[31:25] == OP7_LU12I;
  assign i_jirl  = inst[31:26] == OP6_JIRL;
  assign i_b     = inst[31:26] == OP6_B;
  assign i_bl    = inst[31:26] == OP6_BL;
  assign i_beq   = inst[31:26] == OP6_BEQ;
  assign i_bne   = inst[31:26] == OP6_BNE;

  logic is_3r_op, is_branch, known_op, ctl_en;
  assign is_3r_op  = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
  assign is_branch = i_jirl | i_b | i_bl | i_beq | i_bne;
  assign known_op  = is_3r_op | i_slli | i_srli | i_srai | i_addi | i_lu12i
                   | i_ld | i_st | is_branch;
  // Unknown opcodes carry no side effects into EXE when treated as NOP
  assign ctl_en    = known_op | ~PC_RESET_NOP;

  logic [ALU_OP_W-1:0] alu_op;
  always_comb begin
    alu_op           = '0;
    alu_op[ALU_ADD]  = i_add | i_addi | i_ld | i_st | i_jirl | i_bl;
    alu_op[ALU_SUB]  = i_sub;
    alu_op[ALU_SLT]  = i_slt;
    alu_op[ALU_SLTU] = i_sltu;
    alu_op[ALU_AND]  = i_and;
    alu_op[ALU_NOR]  = i_nor;
    alu_op[ALU_OR]   = i_or;
    alu_op[ALU_XOR]  = i_xor;
    alu_op[ALU_SLL]  = i_slli;
    alu_op[ALU_SRL]  = i_srli;
    alu_op[ALU_SRA]  = i_srai;
    alu_op[ALU_LUI]  = i_lu12i;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  logic [31:0] imm;
  always_comb begin
    imm = 32'd0;
    if (i_addi | i_ld | i_st)          imm = {{20{inst[21]}}, inst[21:10]};
    else if (i_slli | i_srli | i_srai) imm = {27'd0, inst[14:10]};
    else if (i_lu12i)                  imm = {inst[24:5], 12'd0};
    else if (i_jirl | i_bl)            imm = 32'd4;
  end

  logic src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we;
  logic [4:0] dest;
  assign src1_is_pc   = i_jirl | i_bl;
  assign src2_is_imm  = i_slli | i_srli | i_srai | i_addi | i_ld | i_st | i_lu12i | i_jirl | i_bl;
  assign res_from_mem = i_ld;
  assign mem_we       = i_st;
  assign gr_we        = ctl_en & ~(i_st | i_b | i_beq | i_bne);
  assign dest         = i_bl ? 5'd1 : rd;

  logic [4:0]  raddr2;
  logic [31:0] rj_value, rkd_value;
  assign raddr2 = (i_st | i_beq | i_bne) ? rd : rk;

  id_stage_regfile u_regfile (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rj_value),
    .raddr2 (raddr2),
    .rdata2 (rkd_value),
    .we     (WB_to_RF_Bus[37]),
    .waddr  (WB_to_RF_Bus[36:32]),
    .wdata  (WB_to_RF_Bus[31:0])
  );

  // WB results arrive through the regfile bypass, so only EXE/MEM interlock
  logic rj_used, r2_used, hazard, ready_go, fire;
  assign rj_used  = ctl_en & ~(i_b | i_bl | i_lu12i);
  assign r2_used  = is_3r_op | i_st | i_beq | i_bne;
  assign hazard   = id_valid & (
                      (rj_used && rj != 5'd0 &&
                       (dest_hit(EXE_dest_bus, rj) || dest_hit(MEM_dest_bus, rj))) ||
                      (r2_used && raddr2 != 5'd0 &&
                       (dest_hit(EXE_dest_bus, raddr2) || dest_hit(MEM_dest_bus, raddr2))));
  assign ready_go = ~hazard;
  assign fire     = id_valid & ready_go & EXE_Allow_in;

  assign ID_Allow_in     = ~id_valid | (ready_go & EXE_Allow_in);
  assign ID_to_EXE_Valid = id_valid & ready_go;
  assign ID_to_EXE_Bus   = {alu_op, src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we,
                            dest, imm, rj_value, rkd_value, pc};

  logic [31:0] offs16, offs26, br_target;
  logic        rj_eq_rd, br_taken, br_stall;
  assign offs16   = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26   = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign rj_eq_rd = rj_value == rkd_value;
  assign br_taken = fire & (i_b | i_bl | i_jirl | (i_beq & rj_eq_rd) | (i_bne & ~rj_eq_rd));
  assign br_stall = hazard & is_branch;

  always_comb begin
    br_target = 32'd0;
    if (br_taken) begin
      if (i_jirl)           br_target = rj_value + offs16;
      else if (i_b | i_bl)  br_target = pc + offs26;
      else                  br_target = pc + offs16;
    end
  end

  assign br_bus = {br_taken, br_target, br_stall};

endmodule
